// File: rtl/gradient_pkg.sv
// Shared types and default geometry for the gradient pipeline (window buffer, Gx/Gy stage).
package gradient_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_KERNEL_SIZE  = 5;
    localparam int unsigned DEF_IMAGE_WIDTH  = 10;
    localparam int unsigned DEF_IMAGE_HEIGHT = 10;

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [0:DEF_KERNEL_SIZE-1][0:DEF_KERNEL_SIZE-1] window_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

endpackage

// File: rtl/sliding_window_buffer_if.sv
// Pixel-stream in / window-stream out bundle of the sliding window buffer.
interface sliding_window_buffer_if
    import gradient_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
);

    logic [DATA_WIDTH-1:0] i_pixel;
    logic                  i_data_valid;
    logic                  i_start_of_frame;

    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer;
    logic                  o_data_valid;
    logic                  o_start_of_frame;
    logic                  o_frame_error;

    // The buffer itself is the slave; the pixel source / window sink is the master.
    modport slave (
        input  i_pixel,
        input  i_data_valid,
        input  i_start_of_frame,
        output o_image_kernel_buffer,
        output o_data_valid,
        output o_start_of_frame,
        output o_frame_error
    );

    modport master (
        output i_pixel,
        output i_data_valid,
        output i_start_of_frame,
        input  o_image_kernel_buffer,
        input  o_data_valid,
        input  o_start_of_frame,
        input  o_frame_error
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: asynchronous read, synchronous write, no reset.
module line_buffer #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 10,
    parameter int unsigned AddrWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sliding_window_buffer.sv
// Turns a raster pixel stream into KERNEL_SIZE x KERNEL_SIZE windows using KERNEL_SIZE-1
// line buffers and a window shift register; one cycle from accepted pixel to window.
module sliding_window_buffer
    import gradient_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    sliding_window_buffer_if.slave   win_io
);

    localparam int unsigned ColW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned RowW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned K    = KERNEL_SIZE;

    localparam logic [ColW-1:0] ColLast  = ColW'(IMAGE_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(IMAGE_HEIGHT - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);

    typedef logic [0:K-1][0:K-1][DATA_WIDTH-1:0] win_t;

    state_e          state_q;
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    win_t            win_q;
    win_t            win_d;
    logic            valid_q;
    logic            sof_q;
    logic            err_q;

    logic            sof_in;
    logic            accept;
    logic [ColW-1:0] x;
    logic [RowW-1:0] y;

    logic [DATA_WIDTH-1:0] lb_rd [K-1];
    logic [DATA_WIDTH-1:0] lb_wr [K-1];

    // A valid SOF always restarts at (0,0), whatever the current position.
    always_comb begin
        sof_in = win_io.i_data_valid && win_io.i_start_of_frame;
        accept = win_io.i_data_valid && ((state_q == ACTIVE) || win_io.i_start_of_frame);
        x      = sof_in ? '0 : col_q;
        y      = sof_in ? '0 : row_q;
    end

    for (genvar k = 0; k < K - 1; k++) begin : g_lb
        if (k == K - 2) begin : g_newest
            assign lb_wr[k] = win_io.i_pixel;
        end else begin : g_older
            assign lb_wr[k] = lb_rd[k+1];
        end

        line_buffer #(
            .DataWidth (DATA_WIDTH),
            .Depth     (IMAGE_WIDTH),
            .AddrWidth (ColW)
        ) u_line_buffer (
            .clk_i   (i_clk),
            .we_i    (accept),
            .addr_i  (x),
            .wdata_i (lb_wr[k]),
            .rdata_o (lb_rd[k])
        );
    end

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = lb_rd[r];
        end
        win_d[K-1][K-1] = win_io.i_pixel;
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= accept && (x >= ColFirst) && (y >= RowFirst);
            sof_q   <= accept && (x == ColFirst) && (y == RowFirst);
            err_q   <= sof_in && (state_q == ACTIVE);
            if (accept) begin
                win_q <= win_d;
                if (x == ColLast) begin
                    col_q <= '0;
                    if (y == RowLast) begin
                        row_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        row_q   <= y + 1'b1;
                        state_q <= ACTIVE;
                    end
                end else begin
                    col_q   <= x + 1'b1;
                    row_q   <= y;
                    state_q <= ACTIVE;
                end
            end
        end
    end

    assign win_io.o_image_kernel_buffer = win_q;
    assign win_io.o_data_valid          = valid_q;
    assign win_io.o_start_of_frame      = sof_q;
    assign win_io.o_frame_error         = err_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Randomised self-checking bench: each window is rebuilt from a stored copy of the frame.
module tb_sliding_window_buffer;
    import gradient_pkg::*;

    localparam int K = DEF_KERNEL_SIZE;
    localparam int W = DEF_IMAGE_WIDTH;
    localparam int H = DEF_IMAGE_HEIGHT;

    logic i_clk = 1'b0;
    logic i_aresetn = 1'b0;

    sliding_window_buffer_if vif ();

    sliding_window_buffer dut (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .win_io    (vif)
    );

    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int failures  = 0;

    // Reference model state: the current frame as a picture, plus where the next pixel lands.
    pixel_t  img [H][W];
    bit      in_frame;
    int      cx, cy;
    window_t exp_win;
    bit      win_known;

    int      n_valid, n_sof, n_err;
    window_t first_win, last_win;
    pixel_t  first_pix;

    task automatic clear_counts();
        n_valid = 0;
        n_sof   = 0;
        n_err   = 0;
    endtask

    // Drive one cycle, advance the model, and check the registered outputs of that edge.
    task automatic step(input logic v, input pixel_t p, input logic s);
        bit exp_valid, exp_sof, exp_err, acc;
        vif.i_data_valid     = v;
        vif.i_pixel          = p;
        vif.i_start_of_frame = s;
        @(posedge i_clk);
        #1;
        exp_valid = 0; exp_sof = 0; exp_err = 0; acc = 0;
        if (v && s) begin
            exp_err  = in_frame;
            in_frame = 1;
            cx = 0; cy = 0;
            acc = 1;
        end else if (v && in_frame) begin
            acc = 1;
        end
        if (acc) begin
            img[cy][cx] = p;
            if (cx >= K - 1 && cy >= K - 1) begin
                exp_valid = 1;
                exp_sof   = (cx == K - 1) && (cy == K - 1);
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        exp_win[r][c] = img[cy-K+1+r][cx-K+1+c];
                win_known = 1;
            end else begin
                win_known = 0;
            end
            if (cx == W - 1) begin
                cx = 0;
                if (cy == H - 1) begin
                    cy = 0;
                    in_frame = 0;
                end else begin
                    cy++;
                end
            end else begin
                cx++;
            end
        end
        tests_run++;
        if ({vif.o_data_valid, vif.o_start_of_frame, vif.o_frame_error} !==
            {exp_valid, exp_sof, exp_err}) begin
            failures++;
            $display("FAIL flags at pos (%0d,%0d): valid/sof/err got %b%b%b want %b%b%b",
                     cx, cy, vif.o_data_valid, vif.o_start_of_frame, vif.o_frame_error,
                     exp_valid, exp_sof, exp_err);
        end
        if (win_known) begin
            tests_run++;
            if (vif.o_image_kernel_buffer !== exp_win) begin
                failures++;
                $display("FAIL window at pos (%0d,%0d): got %h want %h",
                         cx, cy, vif.o_image_kernel_buffer, exp_win);
            end
        end
        if (vif.o_data_valid === 1'b1) begin
            if (n_valid == 0) first_win = vif.o_image_kernel_buffer;
            last_win = vif.o_image_kernel_buffer;
            n_valid++;
        end
        if (vif.o_start_of_frame === 1'b1) n_sof++;
        if (vif.o_frame_error === 1'b1) n_err++;
    endtask

    task automatic run_frame(input bit rnd, input int gap_max);
        pixel_t p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gap_max > 0 && $urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, gap_max))
                        step(1'b0, pixel_t'($urandom), 1'($urandom));
                p = rnd ? pixel_t'($urandom) : pixel_t'(10 * y + x + 1);
                if (x == 0 && y == 0) first_pix = p;
                step(1'b1, p, (x == 0 && y == 0));
            end
        end
    endtask

    task automatic test_reset();
        vif.i_data_valid = 1'b0;
        vif.i_start_of_frame = 1'b0;
        vif.i_pixel = '0;
        i_aresetn = 1'b0;
        @(posedge i_clk);
        #1;
        i_aresetn = 1'b1;
        in_frame = 0; cx = 0; cy = 0;
        exp_win = '0; win_known = 1;
        tests_run++;
        if ({vif.o_data_valid, vif.o_start_of_frame, vif.o_frame_error,
             vif.o_image_kernel_buffer} !== '0) begin
            failures++;
            $display("FAIL reset outputs: valid/sof/err %b%b%b window %h want all 0",
                     vif.o_data_valid, vif.o_start_of_frame, vif.o_frame_error,
                     vif.o_image_kernel_buffer);
        end
    endtask

    task automatic test_frame();
        clear_counts();
        run_frame(1'b0, 0);
        tests_run++;
        if (n_valid != 36 || n_sof != 1 || n_err != 0) begin
            failures++;
            $display("FAIL frame counts: valid %0d sof %0d err %0d want 36 1 0",
                     n_valid, n_sof, n_err);
        end
        tests_run++;
        if ({first_win[0][0], first_win[0][4], first_win[4][0], first_win[4][4]} !==
            {8'd1, 8'd5, 8'd41, 8'd45}) begin
            failures++;
            $display("FAIL first window corners: got %0d %0d %0d %0d want 1 5 41 45",
                     first_win[0][0], first_win[0][4], first_win[4][0], first_win[4][4]);
        end
        tests_run++;
        if ({last_win[0][0], last_win[4][4]} !== {8'd56, 8'd100}) begin
            failures++;
            $display("FAIL last window corners: got %0d %0d want 56 100",
                     last_win[0][0], last_win[4][4]);
        end
    endtask

    task automatic test_gaps();
        clear_counts();
        run_frame(1'b0, 3);
        repeat (3) step(1'b0, pixel_t'($urandom), 1'($urandom));
        tests_run++;
        if (n_valid != 36 || n_sof != 1 || n_err != 0 || last_win[4][4] !== 8'd100) begin
            failures++;
            $display("FAIL gap frame: valid %0d sof %0d err %0d last %0d want 36 1 0 100",
                     n_valid, n_sof, n_err, last_win[4][4]);
        end
    endtask

    task automatic test_drop_no_sof();
        test_reset();
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, pixel_t'($urandom), 1'b0);
        tests_run++;
        if (n_valid != 0) begin
            failures++;
            $display("FAIL dropped pixels: valid count %0d want 0", n_valid);
        end
        test_frame();
    endtask

    task automatic test_mid_frame_sof();
        clear_counts();
        for (int y = 0; y <= 6; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 6 && x >= 3)) step(1'b1, pixel_t'($urandom), (x == 0 && y == 0));
        tests_run++;
        if (n_valid != 12 || n_err != 0) begin
            failures++;
            $display("FAIL partial frame: valid %0d err %0d want 12 0", n_valid, n_err);
        end
        clear_counts();
        run_frame(1'b1, 2);
        tests_run++;
        if (n_err != 1 || n_valid != 36 || n_sof != 1) begin
            failures++;
            $display("FAIL restart frame: err %0d valid %0d sof %0d want 1 36 1",
                     n_err, n_valid, n_sof);
        end
        tests_run++;
        if (first_win[0][0] !== first_pix) begin
            failures++;
            $display("FAIL restart first window [0][0]: got %0d want %0d",
                     first_win[0][0], first_pix);
        end
    endtask

    task automatic test_reset_mid();
        for (int y = 0; y <= 5; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 5 && x > 4)) step(1'b1, pixel_t'($urandom), (x == 0 && y == 0));
        test_reset();
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, pixel_t'($urandom), 1'b0);
        test_frame();
    endtask

    task automatic test_back_to_back();
        clear_counts();
        run_frame(1'b1, 0);
        run_frame(1'b1, 0);
        tests_run++;
        if (n_valid != 72 || n_sof != 2 || n_err != 0) begin
            failures++;
            $display("FAIL back-to-back: valid %0d sof %0d err %0d want 72 2 0",
                     n_valid, n_sof, n_err);
        end
    endtask

    initial begin
        vif.i_data_valid     = 1'b0;
        vif.i_start_of_frame = 1'b0;
        vif.i_pixel          = '0;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        test_frame();
        test_gaps();
        test_drop_no_sof();
        test_mid_frame_sof();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
